// File: rtl/guided_play_pkg.sv
// Shared types for the guided-play sequencer: FSM states, per-slot status codes
// and the helper that locates a slot's field inside a fetched song row.
package guided_play_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_PEND = 2'b00;
  localparam logic [1:0] ST_HIT  = 2'b01;
  localparam logic [1:0] ST_MISS = 2'b10;
  localparam logic [1:0] ST_REST = 2'b11;

  // Each slot field is {valid, note[note_w-1:0]}, so the stride is note_w+1.
  function automatic int field_lsb(input int slot, input int note_w);
    return slot * (note_w + 1);
  endfunction

endpackage

// File: rtl/next_slot_finder.sv
// Combinational priority encoder: lowest valid slot above (or, when inclusive,
// at or above) from_idx, plus a flag when no such slot exists.
module next_slot_finder #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] valid,
  input  logic [IDX_W-1:0]     from_idx,
  input  logic                 inclusive,
  output logic [IDX_W-1:0]     next_idx,
  output logic                 none_left
);

  always_comb begin
    next_idx  = '0;
    none_left = 1'b1;
    // Scan downwards so the lowest qualifying slot is the last one written.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid[i] && ((IDX_W'(i) > from_idx) || (inclusive && (IDX_W'(i) == from_idx)))) begin
        next_idx  = IDX_W'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/guided_play_engine.sv
// Guided-play sequencer: fetches song rows, scores one-pulse key events against
// the expected slot, and drives cursor/status/score to the renderer. GUIDED_RETRY_EN
// keeps the cursor on a missed slot until the right key is played.
module guided_play_engine
  import guided_play_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int NUM_ROWS    = 16,
  parameter int NOTE_W      = 3,
  parameter int ADDR_W      = 8,
  parameter int CURSOR_X0   = 240,
  parameter int CURSOR_STEP = 125,
  localparam int SLOT_W     = $clog2(NUM_SLOTS),
  localparam int ROW_W      = $clog2(NUM_ROWS),
  localparam int CNT_W      = $clog2(NUM_ROWS * NUM_SLOTS) + 1
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           start_in,
  input  logic [ADDR_W-1:0]              song_base_in,
  input  logic                           key_valid_in,
  input  logic [NOTE_W-1:0]              key_code_in,
  output logic                           row_req_out,
  output logic [ADDR_W-1:0]              row_addr_out,
  input  logic                           row_valid_in,
  input  logic [NUM_SLOTS*(NOTE_W+1)-1:0] row_data_in,
  output logic [NUM_SLOTS*NOTE_W-1:0]    note_codes_out,
  output logic [NUM_SLOTS-1:0]           slot_valid_out,
  output logic [NUM_SLOTS*2-1:0]         slot_status_out,
  output logic [SLOT_W-1:0]              cursor_slot_out,
  output logic [10:0]                    cursor_x_out,
  output logic [ROW_W-1:0]               row_idx_out,
  output logic [CNT_W-1:0]               score_out,
  output logic [CNT_W-1:0]               miss_out,
  output logic                           done_out
);

  state_t                  state;
  logic [ADDR_W-1:0]       song_base;
  logic [NUM_SLOTS-1:0]    missed;

  logic [NUM_SLOTS*NOTE_W-1:0] row_notes;
  logic [NUM_SLOTS-1:0]        row_vld;
  logic [NOTE_W-1:0]           cur_note;
  logic                        cur_missed;
  logic                        key_hit, advance, score_inc;
  logic [SLOT_W-1:0]           load_idx, adv_idx;
  logic                        load_none, adv_none;

  function automatic logic [10:0] x_of(input logic [SLOT_W-1:0] s);
    return 11'(CURSOR_X0 + CURSOR_STEP * int'(s));
  endfunction

  always_comb begin
    row_notes = '0;
    row_vld   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      row_notes[i*NOTE_W +: NOTE_W] = row_data_in[field_lsb(i, NOTE_W) +: NOTE_W];
      row_vld[i]                    = row_data_in[field_lsb(i, NOTE_W) + NOTE_W];
    end
  end

  always_comb begin
    cur_note   = '0;
    cur_missed = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (cursor_slot_out == SLOT_W'(i)) begin
        cur_note   = note_codes_out[i*NOTE_W +: NOTE_W];
        cur_missed = missed[i];
      end
    end
  end

  // Without retry the cursor leaves a slot on its first key, so missed is never
  // set for the cursor slot and the score rule below reduces to "score on hit".
  always_comb begin
    key_hit   = (key_code_in == cur_note);
    score_inc = key_hit && !cur_missed;
`ifdef GUIDED_RETRY_EN
    advance   = key_hit;
`else
    advance   = 1'b1;
`endif
  end

  next_slot_finder #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(SLOT_W)) u_load_finder (
    .valid     (row_vld),
    .from_idx  ('0),
    .inclusive (1'b1),
    .next_idx  (load_idx),
    .none_left (load_none)
  );

  next_slot_finder #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(SLOT_W)) u_adv_finder (
    .valid     (slot_valid_out),
    .from_idx  (cursor_slot_out),
    .inclusive (1'b0),
    .next_idx  (adv_idx),
    .none_left (adv_none)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= S_IDLE;
      song_base       <= '0;
      missed          <= '0;
      row_req_out     <= 1'b0;
      row_addr_out    <= '0;
      note_codes_out  <= '0;
      slot_valid_out  <= '0;
      slot_status_out <= '0;
      cursor_slot_out <= '0;
      cursor_x_out    <= 11'(CURSOR_X0);
      row_idx_out     <= '0;
      score_out       <= '0;
      miss_out        <= '0;
      done_out        <= 1'b0;
    end else if (start_in) begin
      state        <= S_FETCH;
      song_base    <= song_base_in;
      row_addr_out <= song_base_in;
      row_req_out  <= 1'b1;
      row_idx_out  <= '0;
      score_out    <= '0;
      miss_out     <= '0;
      done_out     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (row_valid_in) begin
            row_req_out <= 1'b0;
            if (load_none) begin
              state    <= S_DONE;
              done_out <= 1'b1;
            end else begin
              state           <= S_PLAY;
              note_codes_out  <= row_notes;
              slot_valid_out  <= row_vld;
              missed          <= '0;
              cursor_slot_out <= load_idx;
              cursor_x_out    <= x_of(load_idx);
              for (int i = 0; i < NUM_SLOTS; i++)
                slot_status_out[2*i +: 2] <= row_vld[i] ? ST_PEND : ST_REST;
            end
          end
        end
        S_PLAY: begin
          if (key_valid_in) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (cursor_slot_out == SLOT_W'(i)) begin
                slot_status_out[2*i +: 2] <= key_hit ? ST_HIT : ST_MISS;
                if (!key_hit) missed[i] <= 1'b1;
              end
            end
            if (score_inc) score_out <= score_out + 1'b1;
            // Retries can push misses past the slot count; hold at full scale.
            if (!key_hit && (miss_out != '1)) miss_out <= miss_out + 1'b1;
            if (advance) begin
              if (!adv_none) begin
                cursor_slot_out <= adv_idx;
                cursor_x_out    <= x_of(adv_idx);
              end else if (row_idx_out == ROW_W'(NUM_ROWS - 1)) begin
                state    <= S_DONE;
                done_out <= 1'b1;
              end else begin
                state        <= S_FETCH;
                row_idx_out  <= row_idx_out + 1'b1;
                row_addr_out <= song_base + ADDR_W'(row_idx_out) + ADDR_W'(1);
                row_req_out  <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_guided_play_engine.sv
// Directed self-checking bench for guided_play_engine (default parameters);
// expected values are hand-derived, with GUIDED_RETRY_EN variants where they differ.
module tb_guided_play_engine;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in;
  logic [7:0]  song_base_in;
  logic        key_valid_in;
  logic [2:0]  key_code_in;
  logic        row_req_out;
  logic [7:0]  row_addr_out;
  logic        row_valid_in;
  logic [31:0] row_data_in;
  logic [23:0] note_codes_out;
  logic [7:0]  slot_valid_out;
  logic [15:0] slot_status_out;
  logic [2:0]  cursor_slot_out;
  logic [10:0] cursor_x_out;
  logic [3:0]  row_idx_out;
  logic [7:0]  score_out;
  logic [7:0]  miss_out;
  logic        done_out;

  int n_total = 0;
  int n_pass  = 0;

  guided_play_engine dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .song_base_in    (song_base_in),
    .key_valid_in    (key_valid_in),
    .key_code_in     (key_code_in),
    .row_req_out     (row_req_out),
    .row_addr_out    (row_addr_out),
    .row_valid_in    (row_valid_in),
    .row_data_in     (row_data_in),
    .note_codes_out  (note_codes_out),
    .slot_valid_out  (slot_valid_out),
    .slot_status_out (slot_status_out),
    .cursor_slot_out (cursor_slot_out),
    .cursor_x_out    (cursor_x_out),
    .row_idx_out     (row_idx_out),
    .score_out       (score_out),
    .miss_out        (miss_out),
    .done_out        (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base);
    start_in = 1'b1; song_base_in = base;
    step();
    start_in = 1'b0;
  endtask

  task automatic do_key(input logic [2:0] k);
    key_valid_in = 1'b1; key_code_in = k;
    step();
    key_valid_in = 1'b0;
  endtask

  task automatic do_row(input logic [31:0] d);
    row_valid_in = 1'b1; row_data_in = d;
    step();
    row_valid_in = 1'b0;
  endtask

  function automatic logic [31:0] mk_row(input logic [7:0] vmask);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 3] = 3'(i);
      r[4*i + 3]  = vmask[i];
    end
    return r;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},    {31'd0, row_req_out}, 32'd0);
    chk({tag, "_addr"},   {24'd0, row_addr_out}, 32'd0);
    chk({tag, "_notes"},  {8'd0, note_codes_out}, 32'd0);
    chk({tag, "_valid"},  {24'd0, slot_valid_out}, 32'd0);
    chk({tag, "_status"}, {16'd0, slot_status_out}, 32'd0);
    chk({tag, "_cursor"}, {29'd0, cursor_slot_out}, 32'd0);
    chk({tag, "_x"},      {21'd0, cursor_x_out}, 32'd240);
    chk({tag, "_row"},    {28'd0, row_idx_out}, 32'd0);
    chk({tag, "_score"},  {24'd0, score_out}, 32'd0);
    chk({tag, "_miss"},   {24'd0, miss_out}, 32'd0);
    chk({tag, "_done"},   {31'd0, done_out}, 32'd0);
  endtask

  logic [31:0] row_a, row_b, row_end;
  logic [15:0] exp_st;

  initial begin
    row_a   = mk_row(8'hFF);
    row_b   = mk_row(8'hED);
    row_end = mk_row(8'h00);
    rst_n_in = 1'b0; start_in = 1'b0; song_base_in = '0;
    key_valid_in = 1'b0; key_code_in = '0; row_valid_in = 1'b0; row_data_in = '0;
    step(); step();
    chk_reset_state("rst");
    rst_n_in = 1'b1;
    step();

    do_key(3'd0);
    chk("idle_key_score", {24'd0, score_out}, 32'd0);
    chk("idle_key_miss", {24'd0, miss_out}, 32'd0);

    do_start(8'h20);
    chk("start_req", {31'd0, row_req_out}, 32'd1);
    chk("start_addr", {24'd0, row_addr_out}, 32'h20);
    do_key(3'd0);
    step(); step();
    chk("fetch_wait_req", {31'd0, row_req_out}, 32'd1);
    chk("fetch_key_miss", {24'd0, miss_out}, 32'd0);

    do_row(row_a);
    chk("rowa_req", {31'd0, row_req_out}, 32'd0);
    chk("rowa_notes", {8'd0, note_codes_out}, 32'hFAC688);
    chk("rowa_valid", {24'd0, slot_valid_out}, 32'hFF);
    chk("rowa_x0", {21'd0, cursor_x_out}, 32'd240);
    for (int k = 0; k < 8; k++) begin
      do_key(3'(k));
      if (k < 7) begin
        chk("rowa_cursor", {29'd0, cursor_slot_out}, 32'(k + 1));
        chk("rowa_x", {21'd0, cursor_x_out}, 32'(240 + 125 * (k + 1)));
      end
    end
    chk("rowa_status", {16'd0, slot_status_out}, 32'h5555);
    chk("rowa_score", {24'd0, score_out}, 32'd8);
    chk("rowa_next_req", {31'd0, row_req_out}, 32'd1);
    chk("rowa_next_addr", {24'd0, row_addr_out}, 32'h21);
    chk("rowa_next_row", {28'd0, row_idx_out}, 32'd1);

    do_row(row_b);
    chk("rowb_status", {16'd0, slot_status_out}, 32'h030C);
    chk("rowb_cursor0", {29'd0, cursor_slot_out}, 32'd0);
    do_key(3'd0);
    chk("rowb_jump2", {29'd0, cursor_slot_out}, 32'd2);
    chk("rowb_x2", {21'd0, cursor_x_out}, 32'd490);
    do_key(3'd5);
    chk("wrong_status", {16'd0, slot_status_out}, 32'h032D);
    chk("wrong_miss", {24'd0, miss_out}, 32'd1);
`ifdef GUIDED_RETRY_EN
    chk("retry_cursor", {29'd0, cursor_slot_out}, 32'd2);
    do_key(3'd2);
    chk("retry_status", {16'd0, slot_status_out}, 32'h031D);
    chk("retry_score", {24'd0, score_out}, 32'd9);
    exp_st = 16'h575D;
`else
    exp_st = 16'h576D;
`endif
    chk("rowb_at3", {29'd0, cursor_slot_out}, 32'd3);
    do_key(3'd3);
    chk("rowb_jump5", {29'd0, cursor_slot_out}, 32'd5);
    chk("rowb_x5", {21'd0, cursor_x_out}, 32'd865);
    do_key(3'd5); do_key(3'd6); do_key(3'd7);
    chk("rowb_status_end", {16'd0, slot_status_out}, {16'd0, exp_st});
    chk("rowb_score", {24'd0, score_out}, 32'd13);
    chk("rowb_next_addr", {24'd0, row_addr_out}, 32'h22);

    do_row(row_end);
    chk("end_done", {31'd0, done_out}, 32'd1);
    chk("end_req", {31'd0, row_req_out}, 32'd0);
    chk("end_row", {28'd0, row_idx_out}, 32'd2);
    do_key(3'd0);
    do_row(row_a);
    chk("done_score", {24'd0, score_out}, 32'd13);
    chk("done_miss", {24'd0, miss_out}, 32'd1);
    chk("done_status", {16'd0, slot_status_out}, {16'd0, exp_st});
    chk("done_valid", {24'd0, slot_valid_out}, 32'hED);

    do_start(8'h40);
    chk("restart_done", {31'd0, done_out}, 32'd0);
    chk("restart_score", {24'd0, score_out}, 32'd0);
    do_row(row_a);
    start_in = 1'b1; song_base_in = 8'h40; key_valid_in = 1'b1; key_code_in = 3'd0;
    step();
    start_in = 1'b0; key_valid_in = 1'b0;
    chk("startkey_score", {24'd0, score_out}, 32'd0);
    chk("startkey_addr", {24'd0, row_addr_out}, 32'h40);
    chk("startkey_req", {31'd0, row_req_out}, 32'd1);

    do_row(row_a);
    do_key(3'd0);
    chk("pre_rst_score", {24'd0, score_out}, 32'd1);
    rst_n_in = 1'b0;
    #1;
    chk_reset_state("midrst");
    #3;
    rst_n_in = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
